// File: rtl/ldq_alloc_ctrl_pkg.sv
// Shared sizing constants and index/count types for the load-queue allocator.
package ldq_alloc_ctrl_pkg;

  localparam int unsigned DISPATCH_WIDTH = 4;
  localparam int unsigned COMMIT_WIDTH   = 4;
  localparam int unsigned SIZE_LSQ       = 32;
  localparam int unsigned SIZE_LSQ_LOG   = 5;
  localparam int unsigned ALLOC_CNT_W    = 3;

  typedef logic [SIZE_LSQ_LOG-1:0] ldq_idx_t;
  typedef logic [SIZE_LSQ_LOG:0]   ldq_cnt_t;

endpackage

// File: rtl/ldq_alloc_ctrl_prefix_count.sv
// Exclusive prefix popcount over a valid mask, plus the total; shared with the SQ allocator.
module ldq_prefix_count #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         valid_i,
  output logic [WIDTH-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]            total_o
);

  logic [CW-1:0] acc;

  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prefix_o[i] = acc;
      acc         = acc + CW'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/ldq_alloc_ctrl.sv
// Load-queue head/tail/occupancy owner: tail-side allocation, head-side retirement, flush recovery.
module ldq_alloc_ctrl
  import ldq_alloc_ctrl_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  dispatchReady_i,
  input  logic [DISPATCH_WIDTH-1:0]             dispatchLoad_i,
  input  logic [2:0]                            commitLdCount_i,
  input  logic                                  recoverFlag_i,
  output ldq_idx_t                              ldqHead_o,
  output ldq_idx_t                              ldqTail_o,
  output ldq_cnt_t                              ldqCount_o,
  output ldq_idx_t [DISPATCH_WIDTH-1:0]         ldqAllocIndex_o,
  output logic [2:0]                            ldqAllocCount_o,
  output logic                                  ldqStall_o,
  output logic                                  ldqEmpty_o
);

  ldq_idx_t head_q, head_d;
  ldq_idx_t tail_q, tail_d;
  ldq_cnt_t count_q, count_d;

  logic [DISPATCH_WIDTH-1:0][ALLOC_CNT_W-1:0] prefix;
  logic [ALLOC_CNT_W-1:0]                     load_total;
  logic                                       alloc;
  ldq_cnt_t                                   free_slots;
  ldq_idx_t                                   head_next;

  ldq_prefix_count #(
    .WIDTH (DISPATCH_WIDTH),
    .CW    (ALLOC_CNT_W)
  ) u_prefix (
    .valid_i  (dispatchLoad_i),
    .prefix_o (prefix),
    .total_o  (load_total)
  );

  // Stall looks only at registered occupancy so dispatch has no combinational path into it.
  assign free_slots = ldq_cnt_t'(SIZE_LSQ) - count_q;
  assign ldqStall_o = free_slots < ldq_cnt_t'(DISPATCH_WIDTH);
  assign ldqEmpty_o = (count_q == '0);

  // reset_n gates alloc so the bundle reports nothing allocated while held in reset.
  assign alloc           = dispatchReady_i & ~ldqStall_o & ~recoverFlag_i & reset_n;
  assign ldqAllocCount_o = alloc ? load_total : '0;

  always_comb begin
    ldqAllocIndex_o = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      ldqAllocIndex_o[i] = tail_q + ldq_idx_t'(prefix[i]);
    end
  end

  assign head_next = head_q + ldq_idx_t'(commitLdCount_i);

  always_comb begin
    head_d  = head_next;
    tail_d  = tail_q + ldq_idx_t'(ldqAllocCount_o);
    count_d = count_q + ldq_cnt_t'(ldqAllocCount_o) - ldq_cnt_t'(commitLdCount_i);
    if (recoverFlag_i) begin
      tail_d  = head_next;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign ldqHead_o  = head_q;
  assign ldqTail_o  = tail_q;
  assign ldqCount_o = count_q;

  a_commit_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (commitLdCount_i <= 3'(COMMIT_WIDTH)) && (ldq_cnt_t'(commitLdCount_i) <= count_q))
    else $error("commitLdCount_i exceeds occupancy or commit width");

endmodule
